muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_pkg.sv | 30 +++
 rtl/muldiv_step.sv | 47 ++++
 rtl/muldiv_unit.sv | 140 ++++++++++++++
 tb/tb_muldiv_unit.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
// Also holds the operand magnitude helper.
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_FIX  = 2'b10
  } state_t;

  localparam int ITER_COUNT = 32;
  localparam logic [4:0] LAST_ITER = 5'(ITER_COUNT - 1);

  // Magnitude of a value when treated as signed; raw value otherwise.
  function automatic logic [31:0] abs32(input logic [31:0] v, input logic is_signed);
    if (is_signed && v[31]) begin
      return 32'd0 - v;
    end else begin
      return v;
    end
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the unsigned datapath: shift-add for multiply,
// restoring shift-subtract for divide. acc holds the partial product / remainder.
module muldiv_step (
  input  logic        is_div,
  input  logic [32:0] acc,
  input  logic [31:0] mq,
  input  logic [31:0] opb,
  output logic [32:0] acc_next,
  output logic [31:0] mq_next
);

  logic [32:0] sum;
  logic [32:0] shifted;
  logic [32:0] diff;
  logic        ge;

  // Single-iteration combinational step shared by both operation kinds.
  always_comb begin
    sum      = 33'd0;
    shifted  = 33'd0;
    diff     = 33'd0;
    ge       = 1'b0;
    acc_next = 33'd0;
    mq_next  = 32'd0;
    if (is_div) begin
      shifted = {acc[31:0], mq[31]};
      ge      = (shifted >= {1'b0, opb});
      diff    = shifted - {1'b0, opb};
      if (ge) begin
        acc_next = diff;
      end else begin
        acc_next = shifted;
      end
      mq_next = {mq[30:0], ge};
    end else begin
      // acc[32] stays zero between steps, so the 33-bit sum cannot overflow.
      if (mq[0]) begin
        sum = acc + {1'b0, opb};
      end else begin
        sum = acc;
      end
      acc_next = {1'b0, sum[32:1]};
      mq_next  = {sum[0], mq[31:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative 32-bit MULT/MULTU/DIV/DIVU unit with HI/LO result registers.
// Fixed 33-cycle latency: 32 unsigned steps plus one sign-fix cycle.
module muldiv_unit
  import muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        div_by_zero,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  state_t      state;
  logic        is_div;
  logic        sign_a;
  logic        sign_b;
  logic        dz;
  logic [4:0]  cnt;
  logic [31:0] opb;
  logic [32:0] acc;
  logic [31:0] mq;

  logic [32:0] acc_next;
  logic [31:0] mq_next;
  logic        op_signed;
  logic        op_is_div;
  logic [63:0] prod_fix;
  logic [31:0] quot_fix;
  logic [31:0] rem_fix;

  muldiv_step u_step (
    .is_div   (is_div),
    .acc      (acc),
    .mq       (mq),
    .opb      (opb),
    .acc_next (acc_next),
    .mq_next  (mq_next)
  );

  assign busy = (state != ST_IDLE);

  // Decode the incoming op and build sign-corrected results.
  always_comb begin
    op_signed = (op == OP_MULT) || (op == OP_DIV);
    op_is_div = (op == OP_DIV) || (op == OP_DIVU);
    if (sign_a ^ sign_b) begin
      prod_fix = 64'd0 - {acc[31:0], mq};
      quot_fix = 32'd0 - mq;
    end else begin
      prod_fix = {acc[31:0], mq};
      quot_fix = mq;
    end
    if (sign_a) begin
      rem_fix = 32'd0 - acc[31:0];
    end else begin
      rem_fix = acc[31:0];
    end
  end

  // Control FSM, iteration counter, operand latches and HI/LO registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      is_div      <= 1'b0;
      sign_a      <= 1'b0;
      sign_b      <= 1'b0;
      dz          <= 1'b0;
      cnt         <= 5'd0;
      opb         <= 32'd0;
      acc         <= 33'd0;
      mq          <= 32'd0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= 32'd0;
      lo          <= 32'd0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (hi_we) begin
            hi <= wdata;
          end
          if (lo_we) begin
            lo <= wdata;
          end
          if (start) begin
            is_div <= op_is_div;
            sign_a <= op_signed & A[31];
            sign_b <= op_signed & B[31];
            dz     <= op_is_div & (B == 32'd0);
            opb    <= abs32(B, op_signed);
            mq     <= abs32(A, op_signed);
            acc    <= 33'd0;
            cnt    <= 5'd0;
            state  <= ST_CALC;
          end
        end
        ST_CALC: begin
          acc <= acc_next;
          mq  <= mq_next;
          if (cnt == LAST_ITER) begin
            cnt   <= 5'd0;
            state <= ST_FIX;
          end else begin
            cnt <= cnt + 5'd1;
          end
        end
        ST_FIX: begin
          done        <= 1'b1;
          div_by_zero <= dz;
          // A zero divisor leaves HI/LO exactly as they were.
          if (is_div) begin
            if (!dz) begin
              hi <= rem_fix;
              lo <= quot_fix;
            end
          end else begin
            hi <= prod_fix[63:32];
            lo <= prod_fix[31:0];
          end
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit with hand-computed results.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] A = 32'd0;
  logic [31:0] B = 32'd0;
  logic        hi_we = 1'b0;
  logic        lo_we = 1'b0;
  logic [31:0] wdata = 32'd0;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;
  int lat;
  int busy_bad;

  muldiv_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .op          (op),
    .A           (A),
    .B           (B),
    .hi_we       (hi_we),
    .lo_we       (lo_we),
    .wdata       (wdata),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .hi          (hi),
    .lo          (lo)
  );

  always #5 clk = ~clk;

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Present an op at a negedge; it is accepted at the next posedge (E).
  // Afterwards inputs are scrambled to show the in-flight op ignores them.
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    op = o; A = a; B = b; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; op = ~o; A = 32'hDEADBEEF; B = 32'h00000001;
  endtask

  // Count edges after E until done; bounded so a stuck DUT cannot hang the run.
  task automatic wait_done(output int l, output int bb);
    l = 0;
    bb = (busy !== 1'b1) ? 1 : 0;
    while (l < 40) begin
      @(posedge clk);
      #1;
      l++;
      if (done === 1'b1) break;
      if (busy !== 1'b1) bb++;
    end
  endtask

  initial begin
    #1;
    check1("rst_busy", busy, 1'b0);
    check1("rst_done", done, 1'b0);
    check1("rst_dz", div_by_zero, 1'b0);
    check32("rst_hi", hi, 32'h0);
    check32("rst_lo", lo, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // MULTU max*max, with latency and busy window
    issue(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done(lat, busy_bad);
    check32("multu_lat", 32'(lat), 32'd33);
    check32("multu_busy_window", 32'(busy_bad), 32'd0);
    check1("multu_busy_after", busy, 1'b0);
    check1("multu_dz", div_by_zero, 1'b0);
    check32("multu_hi", hi, 32'hFFFFFFFE);
    check32("multu_lo", lo, 32'h00000001);
    @(posedge clk); #1;
    check1("multu_done_pulse", done, 1'b0);

    issue(2'b00, 32'hFFFFFFFD, 32'd7);
    wait_done(lat, busy_bad);
    check32("mult_lat", 32'(lat), 32'd33);
    check32("mult_hi", hi, 32'hFFFFFFFF);
    check32("mult_lo", lo, 32'hFFFFFFEB);

    issue(2'b10, 32'hFFFFFFF9, 32'd2);
    wait_done(lat, busy_bad);
    check32("div_neg_lo", lo, 32'hFFFFFFFD);
    check32("div_neg_hi", hi, 32'hFFFFFFFF);

    issue(2'b11, 32'd7, 32'd2);
    wait_done(lat, busy_bad);
    check32("divu_lat", 32'(lat), 32'd33);
    check32("divu_lo", lo, 32'd3);
    check32("divu_hi", hi, 32'd1);

    issue(2'b10, 32'h80000000, 32'hFFFFFFFF);
    wait_done(lat, busy_bad);
    check32("div_ovf_lo", lo, 32'h80000000);
    check32("div_ovf_hi", hi, 32'h0);
    check1("div_ovf_dz", div_by_zero, 1'b0);

    // Preload HI/LO in IDLE, then divide by zero
    @(negedge clk);
    hi_we = 1'b1; lo_we = 1'b0; wdata = 32'h12345678;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h9ABCDEF0;
    @(negedge clk);
    lo_we = 1'b0;
    check32("preload_hi", hi, 32'h12345678);
    check32("preload_lo", lo, 32'h9ABCDEF0);
    issue(2'b11, 32'd5, 32'd0);
    wait_done(lat, busy_bad);
    check32("dz_lat", 32'(lat), 32'd33);
    check1("dz_flag", div_by_zero, 1'b1);
    check32("dz_hi", hi, 32'h12345678);
    check32("dz_lo", lo, 32'h9ABCDEF0);
    @(posedge clk); #1;
    check1("dz_flag_clear", div_by_zero, 1'b0);

    // Start together with an HI write: write lands now, result overwrites later
    @(negedge clk);
    op = 2'b11; A = 32'd100; B = 32'd7; start = 1'b1; hi_we = 1'b1; wdata = 32'h0000AAAA;
    @(posedge clk); #1;
    start = 1'b0; hi_we = 1'b0;
    check32("same_cycle_hi_write", hi, 32'h0000AAAA);
    wait_done(lat, busy_bad);
    check32("same_cycle_lo", lo, 32'd14);
    check32("same_cycle_hi", hi, 32'd2);

    // Start and HI write while busy are ignored
    issue(2'b01, 32'd3, 32'd4);
    repeat (4) @(posedge clk);
    #1;
    op = 2'b01; A = 32'd0; B = 32'd0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; hi_we = 1'b1; wdata = 32'hFFFF0000;
    @(posedge clk); #1;
    hi_we = 1'b0;
    lat = 6;
    while (lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (done === 1'b1) break;
    end
    check32("busy_ign_lat", 32'(lat), 32'd33);
    check32("busy_ign_lo", lo, 32'd12);
    check32("busy_ign_hi", hi, 32'd0);
    @(posedge clk); #1;
    check1("busy_ign_no_requeue", busy, 1'b0);

    // Reset in the middle of a MULT aborts it
    issue(2'b00, 32'd5, 32'd6);
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check1("midrst_busy", busy, 1'b0);
    check32("midrst_hi", hi, 32'h0);
    check32("midrst_lo", lo, 32'h0);
    busy_bad = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done !== 1'b0) busy_bad++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) begin
      @(posedge clk); #1;
      if (done !== 1'b0) busy_bad++;
    end
    check32("midrst_no_done", 32'(busy_bad), 32'd0);
    issue(2'b01, 32'd2, 32'd3);
    wait_done(lat, busy_bad);
    check32("postrst_lat", 32'(lat), 32'd33);
    check32("postrst_lo", lo, 32'd6);
    check32("postrst_hi", hi, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
